// File: rtl/tspp_mem_port_arbiter.sv
// Memory port arbiter for the two-stage pipeline.
// Shares one bus port between instruction fetch and data access. Data has
// priority because it belongs to the older instruction. A saturating starve
// counter forces a fetch grant after IFETCH_STARVE_MAX data grants that left a
// fetch waiting. A saturating timeout counter forces completion with a fault
// when the slave holds bus_busy for too long.
module tspp_mem_port_arbiter #(
  parameter int ADDR_W            = 32,
  parameter int DATA_W            = 32,
  parameter int TIMEOUT_CYCLES    = 255,
  parameter int IFETCH_STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction fetch port
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_busy,
  output logic              i_fault,
  // data access port
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_byte_en,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_busy,
  output logic              d_fault,
  // memory bus
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_byte_en,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy,
  input  logic              bus_error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STV_W = $clog2(IFETCH_STARVE_MAX + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(IFETCH_STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [STV_W-1:0]  starve_cnt;

  logic              d_req;
  logic              starved;
  logic              timeout;
  logic              complete;
  logic              grant_i;
  logic              grant_d;
  logic              i_done;
  logic              d_done;
  logic              acc_fault;

  // Request decode and completion detection shared by FSM and outputs.
  always_comb begin
    d_req     = d_ren | d_wen;
    starved   = (starve_cnt == STV_SAT);
    timeout   = (tmo_cnt == TMO_LAST);
    complete  = (state != IDLE) && (!bus_busy || timeout);
    acc_fault = bus_error | timeout;
  end

  // Next-state logic: arbitration in IDLE, wait for completion in x_ACC.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_ren && starved) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = D_ACC;
        end else if (i_ren) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end
      end
      I_ACC, D_ACC: begin
        if (complete) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requester-facing outputs; a requester that dropped its request sees no fault.
  always_comb begin
    i_done  = (state == I_ACC) && complete;
    d_done  = (state == D_ACC) && complete;
    i_busy  = i_ren & ~i_done;
    d_busy  = d_req & ~d_done;
    i_fault = i_done & i_ren & acc_fault;
    d_fault = d_done & d_req & acc_fault;
    i_rdata = bus_rdata;
    d_rdata = bus_rdata;
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus request registers: latched on grant, strobes dropped after completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus_ren     <= 1'b0;
      bus_wen     <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_byte_en <= '0;
    end else if (grant_i) begin
      bus_ren     <= 1'b1;
      bus_wen     <= 1'b0;
      bus_addr    <= i_addr;
      bus_byte_en <= '0;
    end else if (grant_d) begin
      bus_ren     <= d_ren;
      bus_wen     <= d_wen;
      bus_addr    <= d_addr;
      bus_wdata   <= d_wdata;
      bus_byte_en <= d_byte_en;
    end else if (complete) begin
      bus_ren     <= 1'b0;
      bus_wen     <= 1'b0;
    end
  end

  // Timeout counter: counts busy access cycles, cleared outside an access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || complete) begin
      tmo_cnt <= '0;
    end else if (bus_busy && tmo_cnt != TMO_SAT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Starve counter: data grants that bypassed a waiting fetch, cleared by a fetch grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_ren && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tspp_mem_port_arbiter.sv
// Directed bench for tspp_mem_port_arbiter with TIMEOUT_CYCLES=8 and
// IFETCH_STARVE_MAX=4. Inputs change 2 time units after a rising edge and
// outputs are sampled 1 time unit after that.
module tb_tspp_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              i_ren;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_busy;
  logic              i_fault;
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_byte_en;
  logic [DATA_W-1:0] d_rdata;
  logic              d_busy;
  logic              d_fault;
  logic              bus_ren;
  logic              bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_byte_en;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_busy;
  logic              bus_error;

  int errors = 0;
  int checks = 0;

  tspp_mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(8),
    .IFETCH_STARVE_MAX(4)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy), .i_fault(i_fault),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_fault(d_fault),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_error(bus_error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 units after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; i_ren = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; d_byte_en = '0; bus_rdata = '0; bus_busy = 1'b0; bus_error = 1'b0;
    #1;
    check("rst_bus_ren", bus_ren, 0);
    check("rst_bus_wen", bus_wen, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_byte_en", bus_byte_en, 0);
    check("rst_i_fault", i_fault, 0);
    check("rst_d_fault", d_fault, 0);
    check("rst_i_busy", i_busy, 0);
    check("rst_d_busy", d_busy, 0);
    tick(); tick();
    nRST = 1'b1;
    tick();

    // 1: single zero-wait fetch
    i_ren = 1'b1; i_addr = 32'h200; bus_rdata = 32'hDEADBEEF; #1;
    check("t1_c0_i_busy", i_busy, 1);
    check("t1_c0_bus_ren", bus_ren, 0);
    tick(); #1;
    check("t1_c1_bus_ren", bus_ren, 1);
    check("t1_c1_bus_addr", bus_addr, 32'h200);
    check("t1_c1_i_busy", i_busy, 0);
    check("t1_c1_i_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_c1_i_fault", i_fault, 0);
    i_ren = 1'b0;
    tick(); #1;
    check("t1_c2_bus_ren", bus_ren, 0);

    // 2: simultaneous requests, data first
    i_ren = 1'b1; i_addr = 32'h200; d_ren = 1'b1; d_addr = 32'h8000; #1;
    check("t2_c0_i_busy", i_busy, 1);
    check("t2_c0_d_busy", d_busy, 1);
    tick(); #1;
    check("t2_c1_bus_addr", bus_addr, 32'h8000);
    check("t2_c1_bus_ren", bus_ren, 1);
    check("t2_c1_d_busy", d_busy, 0);
    check("t2_c1_i_busy", i_busy, 1);
    d_ren = 1'b0;
    tick(); #1;
    check("t2_c2_bus_ren", bus_ren, 0);
    check("t2_c2_i_busy", i_busy, 1);
    tick(); #1;
    check("t2_c3_bus_addr", bus_addr, 32'h200);
    check("t2_c3_i_busy", i_busy, 0);
    i_ren = 1'b0;
    tick();

    // 3: fetch starvation bound, grants D,D,D,D,I
    i_ren = 1'b1; i_addr = 32'h200; d_ren = 1'b1; d_addr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check($sformatf("t3_d%0d_bus_addr", k), bus_addr, 32'h1000 + 4 * k);
      check($sformatf("t3_d%0d_d_busy", k), d_busy, 0);
      check($sformatf("t3_d%0d_i_busy", k), i_busy, 1);
      d_addr = 32'h1000 + 4 * (k + 1);
      tick();
    end
    #1;
    tick(); #1;
    check("t3_i_bus_addr", bus_addr, 32'h200);
    check("t3_i_i_busy", i_busy, 0);
    check("t3_i_d_busy", d_busy, 1);
    tick();
    // starve counter back at zero: data wins again
    tick(); #1;
    check("t3_after_bus_addr", bus_addr, 32'h1010);
    check("t3_after_d_busy", d_busy, 0);
    d_ren = 1'b0; i_ren = 1'b0;
    tick();

    // 4: write with stuck bus, timeout after 8 access cycles
    d_wen = 1'b1; d_addr = 32'h3000; d_wdata = 32'h12345678; d_byte_en = 4'b0110; bus_busy = 1'b1;
    tick(); #1;
    check("t4_c1_bus_wen", bus_wen, 1);
    check("t4_c1_bus_ren", bus_ren, 0);
    check("t4_c1_bus_wdata", bus_wdata, 32'h12345678);
    check("t4_c1_bus_byte_en", bus_byte_en, 4'b0110);
    check("t4_c1_d_busy", d_busy, 1);
    check("t4_c1_d_fault", d_fault, 0);
    for (int c = 2; c < 8; c++) begin
      tick(); #1;
      check($sformatf("t4_c%0d_d_busy", c), d_busy, 1);
    end
    tick(); #1;
    check("t4_c8_d_busy", d_busy, 0);
    check("t4_c8_d_fault", d_fault, 1);
    d_wen = 1'b0;
    tick(); #1;
    check("t4_c9_bus_wen", bus_wen, 0);
    check("t4_c9_d_fault", d_fault, 0);
    bus_busy = 1'b0;
    tick();

    // 5: slave error on completion only
    d_ren = 1'b1; d_addr = 32'h4000; bus_busy = 1'b1; bus_error = 1'b1;
    tick(); #1;
    check("t5_c1_d_busy", d_busy, 1);
    check("t5_c1_d_fault", d_fault, 0);
    bus_busy = 1'b0; bus_rdata = 32'hCAFEF00D; #1;
    check("t5_c1b_d_busy", d_busy, 0);
    check("t5_c1b_d_fault", d_fault, 1);
    check("t5_c1b_d_rdata", d_rdata, 32'hCAFEF00D);
    d_ren = 1'b0; bus_error = 1'b0;
    tick(); #1;
    check("t5_c2_d_fault", d_fault, 0);
    d_ren = 1'b1; d_addr = 32'h4004;
    tick(); #1;
    check("t5_n_bus_addr", bus_addr, 32'h4004);
    check("t5_n_d_busy", d_busy, 0);
    check("t5_n_d_fault", d_fault, 0);
    d_ren = 1'b0;
    tick();

    // 6: reset in the middle of a fetch access
    i_ren = 1'b1; i_addr = 32'h500; bus_busy = 1'b1;
    tick(); #1;
    check("t6_c1_bus_ren", bus_ren, 1);
    tick();
    nRST = 1'b0; #1;
    check("t6_rst_bus_ren", bus_ren, 0);
    check("t6_rst_bus_addr", bus_addr, 0);
    check("t6_rst_i_fault", i_fault, 0);
    check("t6_rst_i_busy", i_busy, 1);
    i_ren = 1'b0; bus_busy = 1'b0;
    tick();
    nRST = 1'b1;
    d_ren = 1'b1; d_addr = 32'h6000;
    tick(); #1;
    check("t6_d_bus_ren", bus_ren, 1);
    check("t6_d_bus_addr", bus_addr, 32'h6000);
    check("t6_d_d_busy", d_busy, 0);
    check("t6_d_d_fault", d_fault, 0);
    d_ren = 1'b0;
    tick(); #1;
    check("t6_end_bus_ren", bus_ren, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
